wb_master_arbiter: RTL and testbench

Two-master Wishbone arbiter that shares the single peripheral bus (version register, LED controller and later slaves behind the address decoder) between the SPI-to-Wishbone bridge (master 0) and a second bus master, e.g. a serial/debug bridge (master 1). It grants the bus per `cyc` tenure with round-robin fairness and routes data and handshakes back only to the owner. A watchdog terminates stalled cycles with `err`, so an unresponsive slave cannot hang the SPI link.

---
 rtl/wb_master_arbiter.sv | 136 +++++++++++++
 tb/tb_wb_master_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter: per-cyc-tenure round-robin grant, owner-only return path,
// and a stall watchdog that forces err when the slave never terminates a strobe.
module wb_master_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  input  logic                    m0_we_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
  input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
  input  logic                    m0_stb_i,
  input  logic                    m1_stb_i,
  input  logic                    m0_cyc_i,
  input  logic                    m1_cyc_i,
  output logic                    m0_ack_o,
  output logic                    m1_ack_o,
  output logic                    m0_err_o,
  output logic                    m1_err_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  output logic                    s_we_o,
  output logic                    s_stb_o,
  output logic                    s_cyc_o,
  output logic [DATA_WIDTH/8-1:0] s_sel_o,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  output logic [1:0]              grant_o,
  output logic                    timeout_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e          r_state;
  logic            r_last;
  logic [1:0]      r_grant;
  logic [CntW-1:0] r_cnt;

  logic w_own0, w_own1, w_hold, w_fire;

  assign w_own0 = r_grant[0];
  assign w_own1 = r_grant[1];

  // Current owner keeps the bus into the next cycle; anything else resets the watchdog.
  assign w_hold = ((r_state == StOwn0) && m0_cyc_i) || ((r_state == StOwn1) && m1_cyc_i);

  // A same-cycle ack beats the watchdog.
  assign w_fire = s_stb_o && !s_ack_i && (r_cnt == CntW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_last  <= 1'b1;
      r_grant <= 2'b00;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (m0_cyc_i && (!m1_cyc_i || r_last)) begin
            r_state <= StOwn0;
            r_grant <= 2'b01;
            r_last  <= 1'b0;
          end else if (m1_cyc_i) begin
            r_state <= StOwn1;
            r_grant <= 2'b10;
            r_last  <= 1'b1;
          end
        end
        StOwn0: begin
          if (!m0_cyc_i) begin
            if (m1_cyc_i) begin
              r_state <= StOwn1;
              r_grant <= 2'b10;
              r_last  <= 1'b1;
            end else begin
              r_state <= StIdle;
              r_grant <= 2'b00;
            end
          end
        end
        StOwn1: begin
          if (!m1_cyc_i) begin
            if (m0_cyc_i) begin
              r_state <= StOwn0;
              r_grant <= 2'b01;
              r_last  <= 1'b0;
            end else begin
              r_state <= StIdle;
              r_grant <= 2'b00;
            end
          end
        end
        default: begin
          r_state <= StIdle;
          r_grant <= 2'b00;
        end
      endcase

      if (!w_hold || w_fire || !s_stb_o || s_ack_i || s_err_i) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  always_comb begin
    s_cyc_o  = (w_own0 && m0_cyc_i) || (w_own1 && m1_cyc_i);
    s_stb_o  = (w_own0 && m0_stb_i) || (w_own1 && m1_stb_i);
    s_adr_o  = w_own0 ? m0_adr_i : (w_own1 ? m1_adr_i : '0);
    s_dat_o  = w_own0 ? m0_dat_i : (w_own1 ? m1_dat_i : '0);
    s_we_o   = (w_own0 && m0_we_i) || (w_own1 && m1_we_i);
    s_sel_o  = w_own0 ? m0_sel_i : (w_own1 ? m1_sel_i : '0);
    m0_dat_o = w_own0 ? s_dat_i : '0;
    m1_dat_o = w_own1 ? s_dat_i : '0;
    m0_ack_o = s_ack_i && w_own0;
    m1_ack_o = s_ack_i && w_own1;
    m0_err_o = (s_err_i || w_fire) && w_own0;
    m1_err_o = (s_err_i || w_fire) && w_own1;
  end

  assign grant_o   = r_grant;
  assign timeout_o = w_fire;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: one vector per clock cycle, outputs sampled mid-cycle.
module tb_wb_master_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o;
  logic        m0_we_i, m1_we_i, m0_stb_i, m1_stb_i, m0_cyc_i, m1_cyc_i;
  logic [3:0]  m0_sel_i, m1_sel_i, s_sel_o;
  logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic        s_we_o, s_stb_o, s_cyc_o, s_ack_i, s_err_i, timeout_o;
  logic [1:0]  grant_o;

  int n_checks = 0;
  int n_errors = 0;
  int row = 0;

  always #5 clk = ~clk;

  wb_master_arbiter #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m0_adr_i (m0_adr_i),
    .m1_adr_i (m1_adr_i),
    .m0_dat_i (m0_dat_i),
    .m1_dat_i (m1_dat_i),
    .m0_dat_o (m0_dat_o),
    .m1_dat_o (m1_dat_o),
    .m0_we_i  (m0_we_i),
    .m1_we_i  (m1_we_i),
    .m0_sel_i (m0_sel_i),
    .m1_sel_i (m1_sel_i),
    .m0_stb_i (m0_stb_i),
    .m1_stb_i (m1_stb_i),
    .m0_cyc_i (m0_cyc_i),
    .m1_cyc_i (m1_cyc_i),
    .m0_ack_o (m0_ack_o),
    .m1_ack_o (m1_ack_o),
    .m0_err_o (m0_err_o),
    .m1_err_o (m1_err_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_dat_i  (s_dat_i),
    .s_we_o   (s_we_o),
    .s_stb_o  (s_stb_o),
    .s_cyc_o  (s_cyc_o),
    .s_sel_o  (s_sel_o),
    .s_ack_i  (s_ack_i),
    .s_err_i  (s_err_i),
    .grant_o  (grant_o),
    .timeout_o(timeout_o)
  );

  typedef struct {
    logic        rst;
    logic        c0, s0, we0;
    logic [31:0] a0;
    logic        c1, s1, we1;
    logic [31:0] a1;
    logic        ack, err;
    logic [31:0] sdat;
    logic [1:0]  grant;
    logic        tmo;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int rst, input int c0, input int s0, input int we0,
                              input int a0, input int c1, input int s1, input int we1,
                              input int a1, input int ack, input int err, input int sdat,
                              input int grant, input int tmo);
    vec_t v;
    v.rst = (rst != 0); v.c0 = (c0 != 0); v.s0 = (s0 != 0); v.we0 = (we0 != 0);
    v.a0 = a0;          v.c1 = (c1 != 0); v.s1 = (s1 != 0); v.we1 = (we1 != 0);
    v.a1 = a1;          v.ack = (ack != 0); v.err = (err != 0); v.sdat = sdat;
    v.grant = 2'(grant); v.tmo = (tmo != 0);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  // Master write data and byte selects are fixed functions of the address so routing is visible.
  task automatic apply(input vec_t v);
    logic        g0, g1;
    logic [31:0] d0, d1;
    @(negedge clk);
    d0 = 32'hA000_0000 | v.a0;
    d1 = 32'hB000_0000 | v.a1;
    rst_n = v.rst;
    m0_cyc_i = v.c0; m0_stb_i = v.s0; m0_we_i = v.we0; m0_adr_i = v.a0; m0_dat_i = d0;
    m1_cyc_i = v.c1; m1_stb_i = v.s1; m1_we_i = v.we1; m1_adr_i = v.a1; m1_dat_i = d1;
    m0_sel_i = 4'hF; m1_sel_i = 4'h3;
    s_ack_i = v.ack; s_err_i = v.err; s_dat_i = v.sdat;
    #2;
    g0 = v.grant[0];
    g1 = v.grant[1];
    chk("grant",   32'(grant_o),   32'(v.grant));
    chk("s_cyc",   32'(s_cyc_o),   32'((g0 & v.c0) | (g1 & v.c1)));
    chk("s_stb",   32'(s_stb_o),   32'((g0 & v.s0) | (g1 & v.s1)));
    chk("s_we",    32'(s_we_o),    32'((g0 & v.we0) | (g1 & v.we1)));
    chk("s_adr",   s_adr_o,        g0 ? v.a0 : (g1 ? v.a1 : 32'h0));
    chk("s_dat",   s_dat_o,        g0 ? d0 : (g1 ? d1 : 32'h0));
    chk("s_sel",   32'(s_sel_o),   g0 ? 32'hF : (g1 ? 32'h3 : 32'h0));
    chk("m0_ack",  32'(m0_ack_o),  32'(g0 & v.ack));
    chk("m1_ack",  32'(m1_ack_o),  32'(g1 & v.ack));
    chk("m0_err",  32'(m0_err_o),  32'(g0 & (v.err | v.tmo)));
    chk("m1_err",  32'(m1_err_o),  32'(g1 & (v.err | v.tmo)));
    chk("m0_dat",  m0_dat_o,       g0 ? v.sdat : 32'h0);
    chk("m1_dat",  m1_dat_o,       g1 ? v.sdat : 32'h0);
    chk("timeout", 32'(timeout_o), 32'(v.tmo));
    row++;
  endtask

  initial begin
    rst_n = 1'b0;
    {m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i, s_ack_i, s_err_i} = '0;
    {m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i, s_dat_i} = '0;
    m0_sel_i = '0; m1_sel_i = '0;
    repeat (2) @(posedge clk);

    // rst c0 s0 we0 a0      c1 s1 we1 a1      ack err sdat          grant tmo
    tbl.push_back(mk(0, 0,0,0,'h000, 0,0,0,'h000, 0,0,'h0,          2'b00,0)); // reset state
    tbl.push_back(mk(1, 1,1,0,'h000, 0,0,0,'h000, 0,0,'h0,          2'b00,0)); // m0 read request
    tbl.push_back(mk(1, 1,1,0,'h000, 0,0,0,'h000, 1,0,'hDEADBEEF,   2'b01,0));
    tbl.push_back(mk(1, 0,0,0,'h000, 0,0,0,'h000, 0,0,'h1234,       2'b01,0));
    tbl.push_back(mk(0, 0,0,0,'h000, 0,0,0,'h000, 0,0,'h0,          2'b00,0)); // reset: last=1
    tbl.push_back(mk(1, 1,1,0,'h010, 1,1,1,'h020, 0,0,'h0,          2'b00,0)); // contention
    tbl.push_back(mk(1, 1,1,0,'h010, 1,1,1,'h020, 1,0,'hAAAA0001,   2'b01,0)); // m0 first
    tbl.push_back(mk(1, 0,0,0,'h010, 1,1,1,'h020, 0,0,'h0,          2'b01,0));
    tbl.push_back(mk(1, 0,0,0,'h000, 1,1,1,'h020, 1,0,'h5555,       2'b10,0)); // hand-over
    tbl.push_back(mk(1, 0,0,0,'h000, 0,0,0,'h020, 0,0,'h0,          2'b10,0));
    tbl.push_back(mk(1, 1,1,0,'h030, 0,0,0,'h000, 0,0,'h0,          2'b00,0)); // m0 alone
    tbl.push_back(mk(1, 1,1,0,'h030, 1,1,0,'h040, 0,1,'h0,          2'b01,0)); // slave err
    tbl.push_back(mk(1, 0,0,0,'h030, 0,0,0,'h040, 0,0,'h0,          2'b01,0));
    tbl.push_back(mk(1, 1,1,0,'h030, 1,1,0,'h040, 0,0,'h0,          2'b00,0)); // m1 wins now
    tbl.push_back(mk(1, 1,1,0,'h030, 1,1,0,'h040, 1,0,'hCAFE0040,   2'b10,0));
    tbl.push_back(mk(1, 0,0,0,'h030, 0,0,0,'h040, 0,0,'h0,          2'b10,0));
    tbl.push_back(mk(1, 1,1,1,'h100, 1,1,0,'h200, 0,0,'h0,          2'b00,0)); // LED burst
    tbl.push_back(mk(1, 1,1,1,'h100, 1,1,0,'h200, 1,0,'h0,          2'b01,0));
    tbl.push_back(mk(1, 1,1,1,'h100, 1,1,0,'h200, 1,0,'h0,          2'b01,0));
    tbl.push_back(mk(1, 1,1,1,'h100, 1,1,0,'h200, 1,0,'h0,          2'b01,0));
    tbl.push_back(mk(1, 1,1,0,'h100, 1,1,0,'h200, 1,0,'hF,          2'b01,0)); // LED readback
    tbl.push_back(mk(1, 0,0,0,'h100, 1,1,0,'h200, 0,0,'h0,          2'b01,0));
    tbl.push_back(mk(1, 0,0,0,'h100, 1,1,0,'h200, 1,0,'hF,          2'b10,0));
    tbl.push_back(mk(1, 0,0,0,'h000, 0,0,0,'h200, 0,0,'h0,          2'b10,0));
    tbl.push_back(mk(1, 0,0,0,'h000, 0,0,0,'h000, 1,0,'hBAD0ACC,    2'b00,0)); // late ack
    tbl.push_back(mk(1, 0,0,0,'h000, 1,1,1,'h300, 0,0,'h0,          2'b00,0)); // m1 write
    tbl.push_back(mk(1, 0,0,0,'h000, 1,1,1,'h300, 0,0,'h0,          2'b10,0));
    tbl.push_back(mk(0, 0,0,0,'h000, 1,1,1,'h300, 0,0,'h0,          2'b10,0)); // reset mid-write
    tbl.push_back(mk(1, 1,1,0,'h400, 1,1,1,'h300, 0,0,'h0,          2'b00,0));
    tbl.push_back(mk(1, 1,1,0,'h400, 1,1,1,'h300, 1,0,'h1,          2'b01,0)); // m0 wins
    tbl.push_back(mk(1, 0,0,0,'h400, 0,0,0,'h300, 0,0,'h0,          2'b01,0));

    foreach (tbl[i]) apply(tbl[i]);

    // m0 stalls on a slave that never answers: err every 17th cycle, then ack wins the tie.
    apply(mk(1, 1,1,0,'h900, 0,0,0,0, 0,0,0, 2'b00,0));
    repeat (16) apply(mk(1, 1,1,0,'h900, 0,0,0,0, 0,0,0, 2'b01,0));
    apply(mk(1, 1,1,0,'h900, 0,0,0,0, 0,0,0, 2'b01,1));
    repeat (16) apply(mk(1, 1,1,0,'h900, 0,0,0,0, 0,0,0, 2'b01,0));
    apply(mk(1, 1,1,0,'h900, 0,0,0,0, 0,0,0, 2'b01,1));
    repeat (16) apply(mk(1, 1,1,0,'h900, 0,0,0,0, 0,0,0, 2'b01,0));
    apply(mk(1, 1,1,0,'h900, 0,0,0,0, 1,0,'h77, 2'b01,0));
    apply(mk(1, 1,1,0,'h900, 0,0,0,0, 0,0,0, 2'b01,0));
    apply(mk(1, 0,0,0,'h900, 0,0,0,0, 0,0,0, 2'b01,0));

    // Same watchdog on m1's tenure.
    apply(mk(1, 0,0,0,0, 1,1,0,'hA00, 0,0,0, 2'b00,0));
    repeat (16) apply(mk(1, 0,0,0,0, 1,1,0,'hA00, 0,0,0, 2'b10,0));
    apply(mk(1, 0,0,0,0, 1,1,0,'hA00, 0,0,0, 2'b10,1));
    apply(mk(1, 0,0,0,0, 0,0,0,'hA00, 0,0,0, 2'b10,0));
    apply(mk(1, 0,0,0,0, 0,0,0,0, 0,0,0, 2'b00,0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
